md_sched: RTL

Multiply/divide scheduler between the E stage and the HI/LO register pair. It accepts one MD operation per issue and latches its operands. It runs a latency counter while the operation is in flight and commits the result to HI/LO atomically when the counter ends. It also drives the busy and stall signals that hold MD-dependent instructions in D. It replaces the ad-hoc busy/start coupling between the stall unit and the MD datapath with one sequenced owner of HI/LO.

---
 rtl/md_sched_if.sv | 28 ++
 rtl/md_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/md_sched_if.sv
// rtl/md_sched_if.sv - E-stage to multiply/divide scheduler bundle
// Purpose: groups the issue, operand, HI/LO readback and stall signals.
// Ports (master = E stage/stall unit, slave = md_sched):
//   start, op[3:0], a[31:0], b[31:0], rd_hi, md_in_d : master -> slave
//   busy, md_out[31:0], hi[31:0], lo[31:0], stall    : slave -> master
interface md_sched_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        md_in_d;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    modport master (
        output start, op, a, b, rd_hi, md_in_d,
        input  busy, md_out, hi, lo, stall
    );

    modport slave (
        input  start, op, a, b, rd_hi, md_in_d,
        output busy, md_out, hi, lo, stall
    );
endinterface

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning the HI/LO register pair
// Purpose: accepts one MD op per issue, latches operands, counts latency,
//          commits the result to HI/LO atomically, and drives busy/stall.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : md_sched_if.slave (start/op/a/b/rd_hi/md_in_d in;
//           busy/md_out/hi/lo/stall out)
module md_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] hi_q, lo_q, a_q, b_q;
    logic [3:0]  op_q;

    logic [31:0] hi_d, lo_d;
    logic [63:0] prod_s, prod_u, hilo;
    logic [31:0] abs_a, abs_b, div_s_b, div_u_b, q_mag, r_mag, q_u, r_u;
    logic        issue_md;

    assign issue_md = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_MSUBU);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign hilo   = {hi_q, lo_q};

    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case;
    // a zero divisor is replaced by 1 only to keep the operators defined.
    assign abs_a   = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b   = b_q[31] ? (32'd0 - b_q) : b_q;
    assign div_s_b = (b_q == 32'd0) ? 32'd1 : abs_b;
    assign div_u_b = (b_q == 32'd0) ? 32'd1 : b_q;
    assign q_mag   = abs_a / div_s_b;
    assign r_mag   = abs_a % div_s_b;
    assign q_u     = a_q / div_u_b;
    assign r_u     = a_q % div_u_b;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MADD:  {hi_d, lo_d} = hilo + prod_s;
            OP_MADDU: {hi_d, lo_d} = hilo + prod_u;
            OP_MSUB:  {hi_d, lo_d} = hilo - prod_s;
            OP_MSUBU: {hi_d, lo_d} = hilo - prod_u;
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    lo_d = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
                    hi_d = a_q[31] ? (32'd0 - r_mag) : r_mag;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    lo_d = q_u;
                    hi_d = r_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_md) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        cnt_q   <= (bus.op == OP_DIV || bus.op == OP_DIVU) ?
                                   CW'(DIV_CYC) : CW'(MULT_CYC);
                        state_q <= RUN;
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_q <= bus.a;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_q <= bus.a;
                    end
                end
                RUN: begin
                    // Any start seen here is dropped; the stall unit owns preventing it.
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.md_out = bus.rd_hi ? hi_q : lo_q;
    // Covering the issue cycle lets a dependent instruction in D stall before busy rises.
    assign bus.stall  = bus.md_in_d && (bus.busy || issue_md);
endmodule
